// File: rtl/conv3x3_mac_pkg.sv
// Shared widths, defaults and FSM state type for the 3x3 convolution engine.
package conv3x3_mac_pkg;

    // Pixel and weight width; the accumulator default leaves headroom for 9 products.
    localparam int DATA_LEN    = 8;
    localparam int DEF_FILTERS = 32;
    localparam int DEF_TAPS    = 9;
    localparam int DEF_ACC_LEN = 2 * DATA_LEN + 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT_W = 2'd1,
        ST_RUN    = 2'd2,
        ST_DONE   = 2'd3
    } conv_state_e;

endpackage

// File: rtl/conv3x3_mac_mac_unit.sv
// Combinational signed multiply-accumulate: sum = acc_in + sext(a * b).
// Kept separate so a pipeline stage can be inserted without touching the FSM.
module conv3x3_mac_mac_unit
    import conv3x3_mac_pkg::*;
#(
    parameter int DLEN = DATA_LEN,
    parameter int ALEN = DEF_ACC_LEN
) (
    input  logic signed [DLEN-1:0] a,
    input  logic signed [DLEN-1:0] b,
    input  logic signed [ALEN-1:0] acc_in,
    output logic signed [ALEN-1:0] sum
);

    logic signed [2*DLEN-1:0] prod;
    logic signed [ALEN-1:0]   prod_ext;

    // Full-width product, sign-extended to the accumulator width, then added.
    always_comb begin
        prod     = a * b;
        prod_ext = ALEN'(prod);
        sum      = acc_in + prod_ext;
    end

endmodule

// File: rtl/conv3x3_mac.sv
// Sequential 3x3 convolution: one time-shared MAC walks FILTERS x TAPS
// products per accepted window and publishes all filter results at once.
//
// Handshake: `start` is a one-cycle request, accepted only while the block
// is IDLE (busy=0 and out_valid=0); requests at any other time are dropped.
// `out_valid` is a one-cycle pulse with no back-pressure: the consumer must
// take `y` on that cycle. `w_valid` must stay high for the whole RUN, a drop
// aborts the window without a result.
module conv3x3_mac
    import conv3x3_mac_pkg::*;
#(
    parameter int FILTERS = DEF_FILTERS,
    parameter int TAPS    = DEF_TAPS,
    parameter int ACC_LEN = DEF_ACC_LEN
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            w_valid,
    input  logic [FILTERS*TAPS*DATA_LEN-1:0] w,
    input  logic                            start,
    input  logic [TAPS*DATA_LEN-1:0]         x,
    output logic                            busy,
    output logic                            out_valid,
    output logic [FILTERS*ACC_LEN-1:0]       y
);

    localparam int F_W = (FILTERS > 1) ? $clog2(FILTERS) : 1;
    localparam int T_W = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam int I_W = $clog2(FILTERS * TAPS);

    conv_state_e                 state, state_next;
    logic [F_W-1:0]              f_cnt;
    logic [T_W-1:0]              t_cnt;
    logic signed [ACC_LEN-1:0]   acc, acc_in, mac_sum;
    logic [TAPS*DATA_LEN-1:0]    xreg;
    logic [FILTERS*ACC_LEN-1:0]  y_q;
    logic signed [DATA_LEN-1:0]  w_arr [FILTERS*TAPS];
    logic signed [DATA_LEN-1:0]  x_arr [TAPS];
    logic [I_W-1:0]              w_idx;
    logic                        last_tap, last_filt;

    // Unpacked views of the flat weight bus and latched window.
    for (genvar i = 0; i < FILTERS * TAPS; i++) begin : g_w
        assign w_arr[i] = w[i*DATA_LEN +: DATA_LEN];
    end
    for (genvar i = 0; i < TAPS; i++) begin : g_x
        assign x_arr[i] = xreg[i*DATA_LEN +: DATA_LEN];
    end

    // Weight-index mux select and end-of-filter / end-of-run flags.
    always_comb begin
        w_idx     = I_W'(int'(f_cnt) * TAPS + int'(t_cnt));
        last_tap  = (t_cnt == T_W'(TAPS - 1));
        last_filt = (f_cnt == F_W'(FILTERS - 1));
        acc_in    = (t_cnt == '0) ? '0 : acc;
    end

    conv3x3_mac_mac_unit #(
        .DLEN (DATA_LEN),
        .ALEN (ACC_LEN)
    ) u_mac (
        .a      (w_arr[w_idx]),
        .b      (x_arr[t_cnt]),
        .acc_in (acc_in),
        .sum    (mac_sum)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // Next-state decode and status outputs.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        out_valid  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) state_next = w_valid ? ST_RUN : ST_WAIT_W;
            end
            ST_WAIT_W: begin
                busy = 1'b1;
                if (w_valid) state_next = ST_RUN;
            end
            ST_RUN: begin
                busy = 1'b1;
                if (!w_valid)                 state_next = ST_IDLE;
                else if (last_tap && last_filt) state_next = ST_DONE;
            end
            ST_DONE: begin
                out_valid  = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Datapath: window latch, counters, accumulator and per-filter result write.
    always_ff @(posedge clk) begin
        if (rst) begin
            xreg  <= '0;
            acc   <= '0;
            f_cnt <= '0;
            t_cnt <= '0;
            y_q   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        xreg  <= x;
                        acc   <= '0;
                        f_cnt <= '0;
                        t_cnt <= '0;
                    end
                end
                ST_RUN: begin
                    // A cycle with w_valid low is the abort cycle: weights are
                    // not trusted, so nothing is accumulated or written.
                    if (w_valid) begin
                        acc <= mac_sum;
                        if (last_tap) begin
                            y_q[f_cnt*ACC_LEN +: ACC_LEN] <= mac_sum;
                            t_cnt <= '0;
                            f_cnt <= f_cnt + 1'b1;
                        end else begin
                            t_cnt <= t_cnt + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign y = y_q;

endmodule

// File: tb/tb_conv3x3_mac.sv
// Self-checking bench for conv3x3_mac against a plain dot-product model.
module tb_conv3x3_mac;
    import conv3x3_mac_pkg::*;

    localparam int DL = DATA_LEN;
    localparam int NF = DEF_FILTERS;
    localparam int NT = DEF_TAPS;
    localparam int AL = DEF_ACC_LEN;
    localparam int NW = NF * NT;

    // Clock / reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic              w_valid, start, busy, out_valid;
    logic [NW*DL-1:0]  w;
    logic [NT*DL-1:0]  x;
    logic [NF*AL-1:0]  y;

    conv3x3_mac dut (
        .clk       (clk),
        .rst       (rst),
        .w_valid   (w_valid),
        .w         (w),
        .start     (start),
        .x         (x),
        .busy      (busy),
        .out_valid (out_valid),
        .y         (y)
    );

    int wm [NW];
    int xm [NT];
    logic [AL-1:0] exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    // Driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_operands();
        for (int i = 0; i < NW; i++) w[i*DL +: DL] = DL'(wm[i]);
        for (int t = 0; t < NT; t++) x[t*DL +: DL] = DL'(xm[t]);
    endtask

    task automatic rand_operands();
        for (int i = 0; i < NW; i++) wm[i] = int'($urandom_range(0, 255)) - 128;
        for (int t = 0; t < NT; t++) xm[t] = int'($urandom_range(0, 255)) - 128;
    endtask

    // Reference model: each filter is a plain integer dot product.
    task automatic push_expected();
        for (int f = 0; f < NF; f++) begin
            int s = 0;
            for (int t = 0; t < NT; t++) s += wm[f*NT+t] * xm[t];
            exp_q.push_back(AL'(s));
        end
    endtask

    // Pulse start for one cycle; returns positioned in cycle 1.
    task automatic kick();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Advance until out_valid is seen or the budget runs out.
    task automatic wait_out(input int limit, output int lat);
        lat = 0;
        while (out_valid !== 1'b1 && lat < limit) begin
            step();
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; w_valid = 1'b0; start = 1'b0; w = '0; x = '0;
        step(); step();
        rst = 1'b0;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_tests++; if (y !== '0) begin n_fail++; $display("FAIL reset_y got %h want 0", y); end
    endtask

    // Runs one window from IDLE with w_valid high and checks latency and y.
    task automatic test_window(input string name);
        int lat;
        logic [AL-1:0] e;
        w_valid = 1'b1;
        apply_operands();
        push_expected();
        kick();
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL %s busy_c1 got %b want 1", name, busy); end
        wait_out(400, lat);
        n_tests++; if (lat + 1 != 289) begin n_fail++; $display("FAIL %s latency got %0d want 289", name, lat + 1); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL %s busy_done got %b want 0", name, busy); end
        for (int f = 0; f < NF; f++) begin
            e = exp_q.pop_front();
            n_tests++;
            if (y[f*AL +: AL] !== e) begin
                n_fail++;
                $display("FAIL %s y[%0d] got %0d want %0d", name, f, $signed(y[f*AL +: AL]), $signed(e));
            end
        end
        step();
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL %s pulse_width got %b want 0", name, out_valid); end
    endtask

    task automatic test_all_ones();
        for (int i = 0; i < NW; i++) wm[i] = 1;
        for (int t = 0; t < NT; t++) xm[t] = 1;
        test_window("all_ones");
        n_tests++; if (y[0 +: AL] !== AL'(9)) begin n_fail++; $display("FAIL all_ones_const got %0d want 9", y[0 +: AL]); end
    endtask

    task automatic test_ramp();
        for (int i = 0; i < NW; i++) wm[i] = i / NT;
        for (int t = 0; t < NT; t++) xm[t] = t;
        test_window("ramp");
        n_tests++; if (y[31*AL +: AL] !== AL'(1116)) begin n_fail++; $display("FAIL ramp_f31 got %0d want 1116", y[31*AL +: AL]); end
    endtask

    task automatic test_extremes();
        for (int i = 0; i < NW; i++) wm[i] = -128;
        for (int t = 0; t < NT; t++) xm[t] = -128;
        test_window("extremes");
        n_tests++; if (y[5*AL +: AL] !== AL'(147456)) begin n_fail++; $display("FAIL extremes_const got %0d want 147456", $signed(y[5*AL +: AL])); end
    endtask

    // Each new start lands on cycle 290 of the previous run.
    task automatic test_back_to_back();
        for (int k = 0; k < 3; k++) begin
            rand_operands();
            test_window("back_to_back");
        end
    endtask

    task automatic test_wait_w();
        int lat;
        int busy_low = 0;
        logic [AL-1:0] e;
        rand_operands();
        w_valid = 1'b0;
        apply_operands();
        push_expected();
        kick();
        for (int c = 1; c < 20; c++) begin
            if (busy !== 1'b1) busy_low++;
            step();
        end
        w_valid = 1'b1;
        wait_out(400, lat);
        n_tests++; if (busy_low != 0) begin n_fail++; $display("FAIL wait_w busy_low_cycles got %0d want 0", busy_low); end
        n_tests++; if (lat != 289) begin n_fail++; $display("FAIL wait_w latency got %0d want 289", lat); end
        for (int f = 0; f < NF; f++) begin
            e = exp_q.pop_front();
            n_tests++;
            if (y[f*AL +: AL] !== e) begin
                n_fail++;
                $display("FAIL wait_w y[%0d] got %0d want %0d", f, $signed(y[f*AL +: AL]), $signed(e));
            end
        end
        step();
    endtask

    task automatic test_abort();
        int lat;
        rand_operands();
        w_valid = 1'b1;
        apply_operands();
        kick();
        for (int c = 1; c < 100; c++) step();
        w_valid = 1'b0;
        step();
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got %b want 0", busy); end
        wait_out(300, lat);
        n_tests++; if (lat != 300) begin n_fail++; $display("FAIL abort_out_valid got pulse after %0d cycles want none", lat); end
        rand_operands();
        test_window("after_abort");
    endtask

    task automatic test_reset_mid_run();
        int lat;
        rand_operands();
        w_valid = 1'b1;
        apply_operands();
        kick();
        for (int c = 1; c < 50; c++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got %b want 0", busy); end
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid got %b want 0", out_valid); end
        n_tests++; if (y !== '0) begin n_fail++; $display("FAIL midrst_y got %h want 0", y); end
        wait_out(300, lat);
        n_tests++; if (lat != 300) begin n_fail++; $display("FAIL midrst_no_result got pulse after %0d cycles want none", lat); end
    endtask

    task automatic test_start_ignored();
        int pulses = 0;
        int first_c = -1;
        logic [AL-1:0] e;
        rand_operands();
        w_valid = 1'b1;
        apply_operands();
        push_expected();
        kick();
        for (int c = 1; c < 700; c++) begin
            if (out_valid === 1'b1) begin
                pulses++;
                if (first_c < 0) first_c = c;
            end
            if ((c <= 288 && $urandom_range(0, 7) == 0) || c == 289) begin
                start = 1'b1;
                x = NT*DL'({$urandom, $urandom, $urandom});
            end else begin
                start = 1'b0;
            end
            step();
        end
        start = 1'b0;
        n_tests++; if (pulses != 1) begin n_fail++; $display("FAIL ignored_pulses got %0d want 1", pulses); end
        n_tests++; if (first_c != 289) begin n_fail++; $display("FAIL ignored_latency got %0d want 289", first_c); end
        for (int f = 0; f < NF; f++) begin
            e = exp_q.pop_front();
            n_tests++;
            if (y[f*AL +: AL] !== e) begin
                n_fail++;
                $display("FAIL ignored y[%0d] got %0d want %0d", f, $signed(y[f*AL +: AL]), $signed(e));
            end
        end
    endtask

    initial begin
        test_reset();
        test_all_ones();
        test_ramp();
        test_extremes();
        test_back_to_back();
        test_wait_w();
        test_abort();
        test_reset_mid_run();
        test_start_ignored();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
